// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// controller states and the iteration count.
package mdu_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam int ITER_COUNT = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Final result shaping: restores signs on the unsigned magnitude result and
// applies the defined divide-by-zero result.
module mdu_sign_fix
    import mdu_pkg::*;
(
    input  logic [1:0]  op,
    input  logic        res_neg,
    input  logic        rem_neg,
    input  logic        dbz,
    input  logic [63:0] acc,
    input  logic [31:0] raw_a,
    output logic [31:0] hi_res,
    output logic [31:0] lo_res
);

    logic [63:0] prod;

    always_comb begin
        hi_res = '0;
        lo_res = '0;
        prod   = res_neg ? -acc : acc;
        if (!op_is_div(op)) begin
            hi_res = prod[63:32];
            lo_res = prod[31:0];
        end else if (dbz) begin
            hi_res = raw_a;
            lo_res = 32'hFFFF_FFFF;
        end else begin
            // acc holds {remainder, quotient} as magnitudes
            lo_res = res_neg ? -acc[31:0]  : acc[31:0];
            hi_res = rem_neg ? -acc[63:32] : acc[63:32];
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit owning HI/LO: shift-add multiply and
// restoring divide, one bit per cycle, fixed 34-cycle start-to-result latency.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start; MTHI/MTLO only
// ST_ITER | 32 shift-add / restoring-divide steps on magnitudes
// ST_FIX  | sign correction, HI/LO write, done pulse
module mul_div_unit
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] busa,
    input  logic [31:0] busb,
    input  logic        flush,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    state_t      state, next_state;
    logic [4:0]  cnt;
    logic [1:0]  op_q;
    logic [31:0] opnd;
    logic [31:0] raw_a;
    logic [63:0] acc;
    logic        res_neg, rem_neg, dbz;
    logic        done_q;
    logic [31:0] hi_q, lo_q;

    logic        is_signed_in;
    logic [31:0] abs_a, abs_b;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_trial, div_diff;
    logic [63:0] div_next;
    logic [31:0] hi_res, lo_res;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (start) next_state = ST_ITER;
            ST_ITER: if (cnt == 5'(ITER_COUNT - 1)) next_state = ST_FIX;
            ST_FIX:  next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
        if (flush) next_state = ST_IDLE;
    end

    always_comb begin
        is_signed_in = op_is_signed(op);
        abs_a = (is_signed_in && busa[31]) ? -busa : busa;
        abs_b = (is_signed_in && busb[31]) ? -busb : busb;

        // multiply: acc = {partial product, remaining multiplier bits}
        mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        mul_next = {mul_sum, acc[31:1]};

        // divide: acc = {partial remainder, dividend bits / quotient bits}
        div_trial = acc[63:31];
        div_diff  = div_trial - {1'b0, opnd};
        div_next  = div_diff[32] ? {div_trial[31:0], acc[30:0], 1'b0}
                                 : {div_diff[31:0],  acc[30:0], 1'b1};
    end

    mdu_sign_fix u_sign_fix (
        .op      (op_q),
        .res_neg (res_neg),
        .rem_neg (rem_neg),
        .dbz     (dbz),
        .acc     (acc),
        .raw_a   (raw_a),
        .hi_res  (hi_res),
        .lo_res  (lo_res)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            op_q    <= '0;
            opnd    <= '0;
            raw_a   <= '0;
            acc     <= '0;
            res_neg <= 1'b0;
            rem_neg <= 1'b0;
            dbz     <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            done_q <= 1'b0;
            if (hi_we) hi_q <= wdata;
            if (lo_we) lo_q <= wdata;
            case (state)
                ST_IDLE: begin
                    if (start && !flush) begin
                        op_q    <= op;
                        cnt     <= '0;
                        raw_a   <= busa;
                        opnd    <= op_is_div(op) ? abs_b : abs_a;
                        acc     <= {32'd0, op_is_div(op) ? abs_a : abs_b};
                        res_neg <= is_signed_in & (busa[31] ^ busb[31]);
                        rem_neg <= is_signed_in & busa[31];
                        dbz     <= op_is_div(op) & (busb == 32'd0);
                    end
                end
                ST_ITER: begin
                    if (!flush) begin
                        acc <= op_is_div(op_q) ? div_next : mul_next;
                        cnt <= cnt + 5'd1;
                    end
                end
                ST_FIX: begin
                    // placed after MTHI/MTLO so the operation result wins
                    if (!flush) begin
                        hi_q   <= hi_res;
                        lo_q   <= lo_res;
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed corner cases plus random ops
// against an arithmetic reference model.
module tb_mul_div_unit;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, flush, hi_we, lo_we;
    logic [1:0]  op;
    logic [31:0] busa, busb, wdata;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [63:0] res;
        int          issue;
    } exp_t;
    exp_t sb[$];

    mul_div_unit dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .busa  (busa),
        .busb  (busb),
        .flush (flush),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb2;
        sa  = longint'($signed(a));
        sb2 = longint'($signed(b));
        case (o)
            OP_MULT:  return 64'(sa * sb2);
            OP_MULTU: return {32'd0, a} * {32'd0, b};
            OP_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                return {32'(sa % sb2), 32'(sa / sb2)};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // monitor: every done must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done hi=%h lo=%h", hi, lo);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", {hi, lo}, e.res);
                check("latency", 64'(cyc - e.issue), 64'd34);
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit expect_run);
        exp_t e;
        start = 1'b1;
        op    = o;
        busa  = a;
        busb  = b;
        if (expect_run) begin
            e.res   = model(o, a, b);
            e.issue = cyc;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input bit poke);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (poke && i == 5) begin
                start = 1'b1;
                op    = 2'($urandom_range(0, 3));
                busa  = $urandom;
                busb  = $urandom;
            end
            if (done) return;
        end
        checks++;
        failures++;
        $display("FAIL done_timeout busy=%b", busy);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = '0; busa = '0; busb = '0; wdata = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        issue(OP_MULT,  32'hFFFF_FFFD, 32'd7, 1'b1);
        check("busy_after_start", 64'(busy), 64'd1);
        wait_done(1'b0);
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); wait_done(1'b0);
        issue(OP_DIV,   32'hFFFF_FFF9, 32'd2, 1'b1);         wait_done(1'b0);
        issue(OP_DIVU,  32'd100, 32'd7, 1'b1);               wait_done(1'b0);
        issue(OP_DIV,   32'h1234, 32'd0, 1'b1);              wait_done(1'b0);
        issue(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b1); wait_done(1'b1);
        @(negedge clk);
        check("busy_after_done", 64'(busy), 64'd0);

        // MTHI/MTLO preload then flushed DIV
        hi_we = 1'b1; wdata = 32'hAAAA;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h5555;
        @(negedge clk);
        lo_we = 1'b0;
        check("mthi_mtlo", {hi, lo}, {32'hAAAA, 32'h5555});
        issue(OP_DIV, 32'd1000, 32'd3, 1'b0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        repeat (40) @(negedge clk);
        check("flush_hilo", {hi, lo}, {32'hAAAA, 32'h5555});

        // flush beats start in idle
        flush = 1'b1;
        issue(OP_MULT, 32'd5, 32'd5, 1'b0);
        flush = 1'b0;
        check("flush_start_idle", 64'(busy), 64'd0);
        repeat (40) @(negedge clk);

        // MTLO on the FIX edge loses to the product
        issue(OP_MULT, 32'd2, 32'd3, 1'b1);
        repeat (32) @(negedge clk);
        lo_we = 1'b1; wdata = 32'h77;
        @(negedge clk);
        lo_we = 1'b0;
        check("fix_beats_mtlo", 64'(lo), 64'd6);

        for (int n = 0; n < 40; n++) begin
            issue(2'($urandom_range(0, 3)), pick(), pick(), 1'b1);
            wait_done(n % 4 == 1);
        end
        repeat (50) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multiply/divide unit in the execute stage; consumes the `busa`/`busb` operand pair that the operand-select logic drives toward the ALU. Executes MULT, MULTU, DIV and DIVU over 34 cycles using a shift-add / restoring-division datapath, and owns the architectural HI/LO registers. Asserts `busy` so the pipeline controller can stall dependent MFHI/MFLO and any new mul/div instruction.

## Interface
- No parameters; datapath fixed at 32 bits.
- `clk`  in  1  single clock, all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  launch operation; sampled only when idle
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- `busa`  in  32  rs operand (multiplicand / dividend)
- `busb`  in  32  rt operand (multiplier / divisor)
- `flush`  in  1  abort in-flight operation (exception/branch squash)
- `hi_we`, `lo_we`  in  1 each  MTHI / MTLO write strobes
- `wdata`  in  32  MTHI/MTLO data
- `busy`  out  1  operation in flight
- `done`  out  1  one-cycle pulse: HI/LO just updated by an operation
- `hi`, `lo`  out  32 each  architectural HI/LO

## Operation
- States: IDLE, ITER, FIX. `busy` = (state != IDLE), registered.
- IDLE + `start`: latch `op`, |busa|, |busb| (absolute value for signed ops, raw for unsigned), result signs, div-by-zero flag; counter = 0; -> ITER.
- ITER: one step per cycle. MUL: 64-bit shift-add, one multiplier bit per step. DIV: restoring, one quotient bit per step. After step 32 (counter = 31) -> FIX.
- FIX: apply signs, write HI/LO, pulse `done`, -> IDLE.
- Signed sign rules: product sign = a[31]^b[31]; quotient sign = a[31]^b[31]; remainder sign = a[31].
- MULT/MULTU: {hi,lo} = 64-bit product. DIV/DIVU: lo = quotient, hi = remainder.
- Divide by zero (any signedness): lo = 32'hFFFF_FFFF, hi = latched raw `busa`. Defined, not UNPREDICTABLE.
- 0x8000_0000 / -1 (DIV): lo = 0x8000_0000, hi = 0 (falls out of unsigned magnitude + wrap).
- `start` while busy: ignored, not queued.
- `flush`: any state -> IDLE next edge; HI/LO unchanged; no `done`. `flush` and `start` same cycle in IDLE: flush wins, nothing launched.
- `hi_we`/`lo_we`: write `wdata` on the edge, in any state. If the FIX-state write lands on the same edge, the operation result wins.
- Reset: state IDLE, `busy` = 0, `done` = 0, `hi` = 0, `lo` = 0, counter = 0; in-flight operation discarded.

## Timing
- Edge E0: `start` sampled in IDLE. `busy` high from cycle after E0.
- Edges E1..E32: iteration steps. Edge E33: FIX, HI/LO written, state -> IDLE.
- Cycle after E33: `done` = 1, new HI/LO visible, `busy` = 0. Start-to-result latency 34 cycles, identical for all ops and operand values.
- Back-to-back: `start` may be high in the same cycle `done` is high; accepted.
- `hi`/`lo` are direct register outputs; no combinational path from inputs.

## Structure
- Shared package `mdu_pkg`: op encoding constants (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), state enum, iteration count constant (32).
- One natural sub-module: `mdu_sign_fix` (combinational: conditional two's-complement of 64-bit product or 32-bit quotient/remainder, plus div-by-zero override). Controller and iteration datapath stay in the top module.

## Test plan
- MULT busa = 0xFFFF_FFFD (-3), busb = 7 -> `done` 34 cycles after start; hi = 0xFFFF_FFFF, lo = 0xFFFF_FFEB.
- MULTU 0xFFFF_FFFF × 0xFFFF_FFFF -> hi = 0xFFFF_FFFE, lo = 0x0000_0001.
- DIV -7 / 2 -> lo = 0xFFFF_FFFD, hi = 0xFFFF_FFFF. DIVU 100 / 7 -> lo = 0xE, hi = 0x2.
- Div by zero: DIV busa = 0x1234, busb = 0 -> lo = 0xFFFF_FFFF, hi = 0x1234. DIV 0x8000_0000 / 0xFFFF_FFFF -> lo = 0x8000_0000, hi = 0.
- Flush 10 cycles into a DIV with hi/lo preloaded 0xAAAA/0x5555 -> `busy` low next cycle, no `done`, hi/lo unchanged. A new start is then accepted.
- `lo_we` (wdata 0x77) on the FIX edge of a MULT 2×3 -> lo = 6. `start` pulsed while busy -> ignored; only one `done`.
